// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with occupancy count, top peek, pop strobe and sticky error flags
module param_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_idx, top_idx;
    logic rep, wr, rd;
    assign full    = count == CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign wr_idx  = AW'(count);
    assign top_idx = AW'(count - CNT_W'(1));
    assign top     = empty ? '0 : mem[top_idx];
    // push&pop on a non-empty stack swaps the top in place; on empty it degrades to a plain push
    assign rep = push & pop & !empty;
    assign wr  = push & !full & !rep;
    assign rd  = pop & !empty;
    always_ff @(posedge clk) begin
        if (!rst && rep) mem[top_idx] <= data_in;
        else if (!rst && wr) mem[wr_idx] <= data_in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= wr ? count + CNT_W'(1) : (rd && !push) ? count - CNT_W'(1) : count;
            data_out  <= rd ? mem[top_idx] : data_out;
            out_valid <= rd;
            overflow  <= (push & !pop & full) | (overflow & !clr_err);
            underflow <= (pop & empty) | (underflow & !clr_err);
        end
    end
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed scoreboard bench for param_stack at 4x8 and 16x32
module tb_param_stack;
    logic clk = 0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int qa[$], qb[$];

    logic a_rst, a_push, a_pop, a_clr;
    logic [3:0] a_din, a_dout, a_top;
    logic [3:0] a_count;
    logic a_ov, a_full, a_empty, a_ovf, a_unf;

    logic b_rst, b_push, b_pop;
    logic [15:0] b_din, b_dout, b_top;
    logic [5:0] b_count;
    logic b_ov, b_full, b_empty, b_ovf, b_unf;

    param_stack #(.WIDTH(4), .DEPTH(8)) dut_a (
        .clk(clk), .rst(a_rst), .push(a_push), .pop(a_pop), .data_in(a_din), .clr_err(a_clr),
        .data_out(a_dout), .out_valid(a_ov), .top(a_top), .count(a_count), .full(a_full),
        .empty(a_empty), .overflow(a_ovf), .underflow(a_unf));

    param_stack #(.WIDTH(16), .DEPTH(32)) dut_b (
        .clk(clk), .rst(b_rst), .push(b_push), .pop(b_pop), .data_in(b_din), .clr_err(1'b0),
        .data_out(b_dout), .out_valid(b_ov), .top(b_top), .count(b_count), .full(b_full),
        .empty(b_empty), .overflow(b_ovf), .underflow(b_unf));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic a_op(input logic pu, input logic po, input logic [3:0] d, input logic c, input logic r);
        a_push = pu; a_pop = po; a_din = d; a_clr = c; a_rst = r;
        @(posedge clk); #1;
        a_push = 0; a_pop = 0; a_din = 0; a_clr = 0; a_rst = 0;
    endtask

    task automatic b_op(input logic pu, input logic po, input logic [15:0] d, input logic r);
        b_push = pu; b_pop = po; b_din = d; b_rst = r;
        @(posedge clk); #1;
        b_push = 0; b_pop = 0; b_din = 0; b_rst = 0;
    endtask

    always @(negedge clk) begin
        if (a_ov) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_valid: got data_out=%0d expected no strobe", a_dout);
            end else chk("a_pop_data", a_dout, qa.pop_front());
        end
        if (b_ov) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_valid: got data_out=%0d expected no strobe", b_dout);
            end else chk("b_pop_data", b_dout, qb.pop_front());
        end
    end

    initial begin
        a_push = 0; a_pop = 0; a_din = 0; a_clr = 0; a_rst = 1;
        b_push = 0; b_pop = 0; b_din = 0; b_rst = 1;
        @(posedge clk); #1;
        a_op(0, 0, 0, 0, 1);
        a_op(0, 0, 0, 0, 0);
        chk("rst_count", a_count, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_valid", a_ov, 0);
        chk("rst_top", a_top, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_unf", a_unf, 0);

        for (int i = 1; i <= 8; i++) a_op(1, 0, 4'(i), 0, 0);
        chk("fill_full", a_full, 1);
        chk("fill_count", a_count, 8);
        chk("fill_top", a_top, 8);
        for (int i = 8; i >= 1; i--) begin
            qa.push_back(i);
            a_op(0, 1, 0, 0, 0);
            chk("drain_valid", a_ov, 1);
        end
        chk("drain_empty", a_empty, 1);
        chk("drain_count", a_count, 0);

        for (int i = 1; i <= 8; i++) a_op(1, 0, 4'(i), 0, 0);
        a_op(1, 0, 4'hF, 0, 0);
        chk("ovf_count", a_count, 8);
        chk("ovf_top", a_top, 8);
        chk("ovf_flag", a_ovf, 1);
        a_op(0, 0, 0, 1, 0);
        chk("ovf_clr", a_ovf, 0);

        qa.push_back(8);
        a_op(1, 1, 4'hA, 0, 0);
        chk("repfull_count", a_count, 8);
        chk("repfull_ovf", a_ovf, 0);
        chk("repfull_top", a_top, 10);
        qa.push_back(10);
        for (int i = 7; i >= 1; i--) qa.push_back(i);
        repeat (8) a_op(0, 1, 0, 0, 0);

        a_op(0, 1, 0, 0, 0);
        chk("unf_flag", a_unf, 1);
        chk("unf_valid", a_ov, 0);
        chk("unf_dout", a_dout, 1);
        a_op(1, 1, 4'h5, 0, 0);
        chk("pp_empty_count", a_count, 1);
        chk("pp_empty_top", a_top, 5);
        chk("pp_empty_valid", a_ov, 0);

        qa.push_back(5);
        a_op(0, 1, 0, 0, 0);
        a_op(1, 0, 4'h3, 0, 0);
        a_op(1, 0, 4'h7, 0, 0);
        qa.push_back(7);
        a_op(1, 1, 4'h9, 0, 0);
        chk("rep_valid", a_ov, 1);
        chk("rep_count", a_count, 2);
        chk("rep_top", a_top, 9);
        qa.push_back(9); qa.push_back(3);
        a_op(0, 1, 0, 0, 0);
        a_op(0, 1, 0, 0, 0);

        a_op(0, 1, 0, 1, 0);
        chk("clr_vs_err", a_unf, 1);
        a_op(0, 0, 0, 1, 0);
        chk("clr_unf", a_unf, 0);

        for (int i = 1; i <= 4; i++) a_op(1, 0, 4'(i), 0, 0);
        chk("pre_rst_count", a_count, 4);
        a_op(1, 0, 4'h6, 0, 1);
        chk("midrst_count", a_count, 0);
        chk("midrst_top", a_top, 0);
        a_op(1, 0, 4'hC, 0, 0);
        chk("post_rst_top", a_top, 12);
        chk("post_rst_count", a_count, 1);

        b_op(0, 0, 0, 1);
        for (int i = 1; i <= 32; i++) b_op(1, 0, 16'(i * 257), 0);
        chk("b_full", b_full, 1);
        chk("b_count", b_count, 32);
        chk("b_top", b_top, 32 * 257);
        b_op(1, 0, 16'hFFFF, 0);
        chk("b_ovf", b_ovf, 1);
        for (int i = 32; i >= 1; i--) begin
            qb.push_back(i * 257);
            b_op(0, 1, 0, 0);
        end
        chk("b_empty", b_empty, 1);
        chk("b_unf", b_unf, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_left", qa.size(), 0);
        chk("b_queue_left", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
